// File: rtl/sr_fetch_buffer_pkg.sv
// Shared defaults for the schoolRISCV fetch front end.
package sr_fetch_buffer_pkg;

    // Fetch PC after reset (word-aligned).
    localparam logic [31:0] SR_RESET_PC = 32'h0000_0000;

    // Default data/PC width.
    localparam int SR_XLEN = 32;

endpackage

// File: rtl/sr_fifo_sync.sv
// Synchronous FIFO: DEPTH x WIDTH storage, wrap-around pointers, occupancy
// count and a synchronous clear that empties it in one cycle.
module sr_fifo_sync #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    // Next pointers and count; clear wins over push/pop.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the count alone says which entries are meaningful.
        if (push && !clr) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/sr_fetch_buffer.sv
// Instruction-fetch front end: pipelined in-order word reads, up to MAX_OUTST
// requests in flight, returned words buffered with their PC, redirect flush
// with dropping of stale in-flight responses.
module sr_fetch_buffer
    import sr_fetch_buffer_pkg::*;
#(
    parameter int              XLEN      = SR_XLEN,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(SR_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            im_req,
    output logic [XLEN-3:0] im_addr,
    input  logic            im_ardy,
    input  logic            im_drdy,
    input  logic [XLEN-1:0] im_data,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic            fetch_err
);

    localparam int AW = XLEN - 2;
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;

    // PCs are held as word addresses; the low two bits are always zero.
    logic [AW-1:0]     fetch_word_q, fetch_word_d;
    logic [AW-1:0]     resp_word_q,  resp_word_d;
    logic [OW-1:0]     outst_q, outst_d;   // issued, not yet answered
    logic [OW-1:0]     drop_q,  drop_d;    // of those, answers to discard
    logic              fetch_err_q, fetch_err_d;

    logic [CW-1:0]     fifo_count;
    logic [2*XLEN-1:0] fifo_head;
    logic              fifo_push;
    logic              fifo_pop;
    logic [SW-1:0]     credit_sum;
    logic              issue;
    logic              resp_valid;
    logic [AW-1:0]     redirect_word;

    // Live requests plus buffered words must leave room in the FIFO, so a
    // valid answer can never find it full.
    assign credit_sum    = SW'(outst_q - drop_q) + SW'(fifo_count);
    assign im_req        = !rst && !redirect && (outst_q < OW'(MAX_OUTST))
                           && (credit_sum < SW'(DEPTH));
    assign issue         = im_req && im_ardy;
    assign resp_valid    = im_drdy && (outst_q != '0);
    assign redirect_word = AW'(redirect_pc >> 2);

    // Next fetch/response PCs, credit counters and error flag.
    always_comb begin
        fetch_word_d = fetch_word_q;
        resp_word_d  = resp_word_q;
        outst_d      = outst_q;
        drop_d       = drop_q;
        fifo_push    = 1'b0;
        fetch_err_d  = fetch_err_q || (im_drdy && (outst_q == '0));
        if (redirect) begin
            // Nothing issues; whatever is still in flight after this cycle is stale.
            fetch_word_d = redirect_word;
            resp_word_d  = redirect_word;
            outst_d      = outst_q - OW'(resp_valid);
            drop_d       = outst_d;
        end else begin
            if (issue) fetch_word_d = fetch_word_q + AW'(1);
            outst_d = outst_q + OW'(issue) - OW'(resp_valid);
            if (resp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - OW'(1);
                end else begin
                    fifo_push   = 1'b1;
                    resp_word_d = resp_word_q + AW'(1);
                end
            end
        end
    end

    // Front-end state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_word_q <= RESET_PC[XLEN-1:2];
            resp_word_q  <= RESET_PC[XLEN-1:2];
            outst_q      <= '0;
            drop_q       <= '0;
            fetch_err_q  <= 1'b0;
        end else begin
            fetch_word_q <= fetch_word_d;
            resp_word_q  <= resp_word_d;
            outst_q      <= outst_d;
            drop_q       <= drop_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    assign fifo_pop = instr_valid && instr_ready;

    sr_fifo_sync #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({resp_word_q, 2'b00, im_data}),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    assign im_addr     = rst ? '0 : fetch_word_q;
    assign instr_valid = !rst && !redirect && (fifo_count != '0);
    assign instr       = rst ? '0 : fifo_head[XLEN-1:0];
    assign instr_pc    = rst ? '0 : fifo_head[2*XLEN-1:XLEN];
    assign fetch_err   = !rst && fetch_err_q;

endmodule

// File: tb/tb_sr_fetch_buffer.sv
// Self-checking bench for sr_fetch_buffer: an in-order memory model with
// configurable latency and accept rate, and a reference model that tracks the
// expected PC of the next instruction delivered to decode.
module tb_sr_fetch_buffer;

    localparam int XLEN      = 32;
    localparam int DEPTH     = 4;
    localparam int MAX_OUTST = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        im_req;
    logic [29:0] im_addr;
    logic        im_ardy = 1'b0;
    logic        im_drdy = 1'b0;
    logic [31:0] im_data = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        fetch_err;

    sr_fetch_buffer #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .MAX_OUTST (MAX_OUTST),
        .RESET_PC  (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ardy     (im_ardy),
        .im_drdy     (im_drdy),
        .im_data     (im_data),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Memory model: accepted word addresses with the cycle they may answer.
    logic [29:0] mq_addr[$];
    int          mq_due[$];
    int          cyc       = 0;
    int          lat       = 1;
    int          ardy_pct  = 100;
    int          ready_pct = 100;

    // Reference model and observation state.
    logic [31:0] exp_pc     = '0;
    int          pops       = 0;
    int          issues     = 0;
    bit          prev_stall = 0;
    logic [29:0] prev_addr  = '0;
    logic        last_req, last_valid, last_drdy;
    logic [29:0] last_addr;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // One clock cycle: drive at negedge, sample 1ns later, account for the coming posedge.
    task automatic cycle(input bit r, input bit rd, input logic [31:0] tgt, input bit spur);
        @(negedge clk);
        rst         = r;
        redirect    = rd;
        redirect_pc = tgt;
        im_ardy     = (int'($urandom_range(99)) < ardy_pct);
        instr_ready = (int'($urandom_range(99)) < ready_pct);
        if (spur) begin
            im_drdy = 1'b1;
            im_data = 32'hDEAD_BEEF;
        end else if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            im_drdy = 1'b1;
            im_data = mem_word(mq_addr[0]);
        end else begin
            im_drdy = 1'b0;
            im_data = $urandom;
        end
        #1;
        last_req   = im_req;
        last_valid = instr_valid;
        last_drdy  = im_drdy;
        last_addr  = im_addr;
        if (r) begin
            vectors++;
            if ({im_req, im_addr, instr_valid, instr, instr_pc, fetch_err} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: req=%b addr=%h valid=%b instr=%h pc=%h err=%b, required all 0",
                         im_req, im_addr, instr_valid, instr, instr_pc, fetch_err);
            end
        end else begin
            if (rd) begin
                vectors++;
                if (instr_valid !== 1'b0 || im_req !== 1'b0) begin
                    miscompares++;
                    $display("FAIL redirect_quiet: valid=%b req=%b, required 0 0", instr_valid, im_req);
                end
            end
            if (prev_stall && im_req) begin
                vectors++;
                if (im_addr !== prev_addr) begin
                    miscompares++;
                    $display("FAIL addr_hold: got %h, required %h", im_addr, prev_addr);
                end
            end
            if (instr_valid && instr_ready) begin
                vectors++;
                if (instr_pc !== exp_pc || instr !== mem_word(exp_pc[31:2])) begin
                    miscompares++;
                    $display("FAIL pop_stream: got pc=%h instr=%h, required pc=%h instr=%h",
                             instr_pc, instr, exp_pc, mem_word(exp_pc[31:2]));
                end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (im_req && im_ardy) begin
                mq_addr.push_back(im_addr);
                mq_due.push_back(cyc + lat);
                issues++;
            end
            if (im_drdy && !spur) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            vectors++;
            if (mq_addr.size() > MAX_OUTST) begin
                miscompares++;
                $display("FAIL outstanding: got %0d in flight, required <= %0d", mq_addr.size(), MAX_OUTST);
            end
        end
        prev_stall = !r && im_req && !im_ardy;
        prev_addr  = im_addr;
        if (!r && rd) exp_pc = tgt & ~32'h3;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Memory is quiesced across reset: nothing stays in flight.
    task automatic do_reset();
        mq_addr.delete();
        mq_due.delete();
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        exp_pc     = 32'h0;
        issues     = 0;
        pops       = 0;
        prev_stall = 0;
    endtask

    task automatic test_reset();
        lat = 1; ardy_pct = 100; ready_pct = 100;
        do_reset();
        run(1);
        vectors++;
        if (last_req !== 1'b1 || last_addr !== 30'h0) begin
            miscompares++;
            $display("FAIL reset_release_req: req=%b addr=%h, required 1 0", last_req, last_addr);
        end
    endtask

    task automatic test_stream();
        int first_valid;
        int gaps;
        lat = 1; ardy_pct = 100; ready_pct = 100;
        do_reset();
        first_valid = -1;
        gaps = 0;
        for (int i = 0; i < 30; i++) begin
            run(1);
            if (last_valid && first_valid < 0) first_valid = i;
            if (first_valid >= 0 && !last_valid) gaps++;
        end
        vectors++;
        if (first_valid != 2) begin
            miscompares++;
            $display("FAIL stream_first_valid: got cycle %0d, required 2", first_valid);
        end
        vectors++;
        if (gaps != 0 || pops != 28) begin
            miscompares++;
            $display("FAIL stream_no_gaps: gaps=%0d pops=%0d, required 0 28", gaps, pops);
        end
    endtask

    task automatic test_backpressure();
        lat = 1; ardy_pct = 100; ready_pct = 0;
        do_reset();
        run(12);
        vectors++;
        if (issues != DEPTH || last_req !== 1'b0 || last_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_fill: issues=%0d req=%b valid=%b, required %0d 0 1",
                     issues, last_req, last_valid, DEPTH);
        end
        ready_pct = 100;
        run(4);
        vectors++;
        if (pops != 4 || exp_pc != 32'h10) begin
            miscompares++;
            $display("FAIL backpressure_drain: pops=%0d next_pc=%h, required 4 00000010", pops, exp_pc);
        end
    endtask

    task automatic test_latency();
        lat = 3; ardy_pct = 50; ready_pct = 70;
        do_reset();
        run(400);
        vectors++;
        if (pops < 50) begin
            miscompares++;
            $display("FAIL latency_progress: pops=%0d, required >= 50", pops);
        end
    endtask

    task automatic test_redirect();
        int waited;
        lat = 3; ardy_pct = 100; ready_pct = 100;
        do_reset();
        waited = 0;
        while (mq_addr.size() != 2 && waited < 20) begin
            run(1);
            waited++;
        end
        vectors++;
        if (mq_addr.size() != 2) begin
            miscompares++;
            $display("FAIL redirect_setup: in flight=%0d, required 2", mq_addr.size());
        end
        cycle(1'b0, 1'b1, 32'h100, 1'b0);
        run(20);
        vectors++;
        if (exp_pc < 32'h104 || exp_pc > 32'h100 + 32'd80) begin
            miscompares++;
            $display("FAIL redirect_resume: next_pc=%h, required 00000104..00000150", exp_pc);
        end
    endtask

    task automatic test_redirect_collide();
        lat = 1; ardy_pct = 100; ready_pct = 100;
        do_reset();
        run(6);
        cycle(1'b0, 1'b1, 32'h203, 1'b0);
        vectors++;
        if (last_drdy !== 1'b1) begin
            miscompares++;
            $display("FAIL collide_drdy: im_drdy=%b, required 1", last_drdy);
        end
        run(10);
        vectors++;
        if (exp_pc < 32'h204 || exp_pc > 32'h228) begin
            miscompares++;
            $display("FAIL collide_resume: next_pc=%h, required 00000204..00000228", exp_pc);
        end
    endtask

    task automatic test_fetch_err_wrap();
        lat = 1; ardy_pct = 100; ready_pct = 100;
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        run(1);
        vectors++;
        if (fetch_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_set: got %b, required 1", fetch_err);
        end
        run(8);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        run(10);
        vectors++;
        if (exp_pc < 32'h4 || exp_pc > 32'h28) begin
            miscompares++;
            $display("FAIL pc_wrap: next_pc=%h, required 00000004..00000028", exp_pc);
        end
        vectors++;
        if (fetch_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: got %b, required 1", fetch_err);
        end
        do_reset();
        run(1);
        vectors++;
        if (fetch_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_cleared: got %b, required 0", fetch_err);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_latency();
        test_redirect();
        test_redirect_collide();
        test_fetch_err_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
